vga_pixel_pipe: RTL and testbench

//  Downstream of vga_sync: consumes HorizontalCounter/VerticalCounter and the raw syncs and

---
 rtl/vga_pixel_pipe_if.sv | 35 +++
 rtl/vga_pixel_pipe.sv | 165 ++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_pipe_if.sv
// Signal bundle between vga_sync/framebuffer (master side) and vga_pixel_pipe (slave side).
// Carries raw timing in, framebuffer read port, and the aligned VGA pins out.
interface vga_pixel_pipe_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              horizontal_sync;
  logic              vertical_sync;
  logic [9:0]        horizontal_counter;
  logic [9:0]        vertical_counter;
  logic [1:0]        pattern_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [11:0]       mem_data;
  logic              vga_hs;
  logic              vga_vs;
  logic [3:0]        vga_r;
  logic [3:0]        vga_g;
  logic [3:0]        vga_b;
  logic              frame_start;
  logic [7:0]        frame_count;

  modport master (
    output horizontal_sync, vertical_sync, horizontal_counter, vertical_counter, pattern_sel,
    output mem_data,
    input  mem_addr, mem_rd_en,
    input  vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start, frame_count
  );

  modport slave (
    input  horizontal_sync, vertical_sync, horizontal_counter, vertical_counter, pattern_sel,
    input  mem_data,
    output mem_addr, mem_rd_en,
    output vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start, frame_count
  );
endinterface

// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipeline: turns raw sync/counters into aligned sync + 4:4:4 RGB pins, sourcing
// pixels from a fixed-latency framebuffer read port or from built-in test patterns.
module vga_pixel_pipe #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic             clock25,
  input logic             reset_n,
  vga_pixel_pipe_if.slave bus
);

  localparam logic [9:0]        HActive  = 10'(H_ACTIVE);
  localparam logic [9:0]        VActive  = 10'(V_ACTIVE);
  localparam logic [9:0]        BarWidth = 10'(H_ACTIVE / 8);
  localparam logic [ADDR_W-1:0] FbWidth  = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

  typedef enum logic [0:0] {StWaitFrame, StRun} state_e;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       active;
    logic       run;
    logic [1:0] mode;
    logic [9:0] h;
    logic [9:0] v;
  } pix_t;

  localparam pix_t PixReset = '{hs: 1'b1, vs: 1'b1, active: 1'b0, run: 1'b0, mode: 2'd0,
                                h: 10'd0, v: 10'd0};

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [9:0]        h0_q, v0_q;
  logic              hs0_q, vs0_q;
  pix_t              s0;
  pix_t              dly_q [MEM_LATENCY];
  pix_t              px;
  logic              at_origin;
  logic              active_in;
  logic              rd_en_d;
  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_en_q;
  logic [2:0]        bar;
  logic [11:0]       pat_rgb;
  logic              show;
  logic              frame_start_d;
  logic              vga_hs_q, vga_vs_q;
  logic [11:0]       rgb_q;
  logic              frame_start_q;
  logic [7:0]        frame_count_q;

  assign at_origin = (bus.horizontal_counter == 10'd0) && (bus.vertical_counter == 10'd0);
  assign active_in = (bus.horizontal_counter < HActive) && (bus.vertical_counter < VActive);
  assign addr_in   = ADDR_W'(bus.vertical_counter >> SCALE_SHIFT) * FbWidth
                   + ADDR_W'(bus.horizontal_counter >> SCALE_SHIFT);

  // Mode is latched only at (0,0) so a frame never mixes sources.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (at_origin) begin
      mode_d = bus.pattern_sel;
    end
    unique case (state_q)
      StWaitFrame: if (at_origin) state_d = StRun;
      StRun:       state_d = StRun;
    endcase
  end

  // Read issued alongside stage 0 using next-state mode/state, so memory data lands exactly
  // when the delayed pixel reaches the output register.
  assign rd_en_d = (state_d == StRun) && (mode_d == 2'd0) && active_in;

  always_ff @(posedge clock25) begin
    if (!reset_n) begin
      state_q     <= StWaitFrame;
      mode_q      <= 2'd0;
      h0_q        <= 10'd0;
      v0_q        <= 10'd0;
      hs0_q       <= 1'b1;
      vs0_q       <= 1'b1;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      h0_q        <= bus.horizontal_counter;
      v0_q        <= bus.vertical_counter;
      hs0_q       <= bus.horizontal_sync;
      vs0_q       <= bus.vertical_sync;
      mem_rd_en_q <= rd_en_d;
      if (rd_en_d) begin
        mem_addr_q <= addr_in;
      end
    end
  end

  assign s0 = '{hs: hs0_q, vs: vs0_q, active: (h0_q < HActive) && (v0_q < VActive),
                run: (state_q == StRun), mode: mode_q, h: h0_q, v: v0_q};

  always_ff @(posedge clock25) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        dly_q[i] <= PixReset;
      end
    end else begin
      dly_q[0] <= s0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign px  = dly_q[MEM_LATENCY-1];
  assign bar = 3'(px.h / BarWidth);

  always_comb begin
    pat_rgb = 12'h000;
    case (px.mode)
      2'd0: pat_rgb = bus.mem_data;
      // Bar order white..black maps to inverted index bits: R=~b1, G=~b2, B=~b0.
      2'd1: pat_rgb = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
      2'd2: pat_rgb = (px.h[5] ^ px.v[5]) ? 12'hFFF : 12'h000;
      2'd3: pat_rgb = ((px.h[4:0] == 5'd0) || (px.v[4:0] == 5'd0)) ? 12'hFFF : 12'h000;
      default: pat_rgb = 12'h000;
    endcase
  end

  assign show          = px.run && px.active;
  assign frame_start_d = show && (px.h == 10'd0) && (px.v == 10'd0);

  always_ff @(posedge clock25) begin
    if (!reset_n) begin
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      vga_hs_q      <= px.hs;
      vga_vs_q      <= px.vs;
      rgb_q         <= show ? pat_rgb : 12'h000;
      frame_start_q <= frame_start_d;
      if (frame_start_d) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.vga_hs      = vga_hs_q;
  assign bus.vga_vs      = vga_vs_q;
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe: drives counters/syncs directly, models a 2-cycle
// framebuffer returning addr[11:0], and checks pins against hand-computed values.
module tb_vga_pixel_pipe;

  localparam int L = 4;

  logic clock25 = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock25 = ~clock25;

  vga_pixel_pipe_if bus ();

  vga_pixel_pipe dut (
    .clock25 (clock25),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [11:0] mem_p1 = 12'h000;
  logic [11:0] mem_p2 = 12'h000;
  always @(posedge clock25) begin
    mem_p1 <= bus.mem_rd_en ? bus.mem_addr[11:0] : 12'h000;
    mem_p2 <= mem_p1;
  end
  assign bus.mem_data = mem_p2;

  typedef struct {
    int          h;
    int          v;
    int          sel;
    logic [11:0] rgb;
  } px_t;

  px_t        tbl[$];
  int         checks = 0;
  int         errors = 0;
  int         cur_sel = 0;
  logic [7:0] exp_fc = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb_out();
    return {20'd0, bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  task automatic drive(input int h, input int v, input int sel);
    @(posedge clock25);
    #1;
    bus.horizontal_counter = 10'(h);
    bus.vertical_counter   = 10'(v);
    bus.horizontal_sync    = !(h >= 656 && h < 752);
    bus.vertical_sync      = !(v >= 490 && v < 492);
    bus.pattern_sel        = 2'(sel);
    cur_sel                = sel;
  endtask

  // Output after drive k shows the pixel of drive k-L.
  task automatic run_tbl();
    int n;
    n = tbl.size();
    for (int i = 0; i < n + L; i++) begin
      px_t  p;
      logic fs;
      if (i < n) drive(tbl[i].h, tbl[i].v, tbl[i].sel);
      else       drive(700, 10, cur_sel);
      if (i >= L) begin
        p  = tbl[i-L];
        fs = (p.h == 0) && (p.v == 0);
        if (fs) exp_fc = exp_fc + 8'd1;
        check($sformatf("rgb(%0d,%0d)", p.h, p.v), rgb_out(), 32'(p.rgb));
        check($sformatf("frame_start(%0d,%0d)", p.h, p.v), 32'(bus.frame_start), 32'(fs));
        check($sformatf("frame_count(%0d,%0d)", p.h, p.v), 32'(bus.frame_count), 32'(exp_fc));
      end
    end
    tbl.delete();
  endtask

  initial begin
    bus.horizontal_counter = 10'd700;
    bus.vertical_counter   = 10'd500;
    bus.horizontal_sync    = 1'b0;
    bus.vertical_sync      = 1'b1;
    bus.pattern_sel        = 2'd0;

    // Reset held for 3 cycles.
    repeat (3) drive(700, 500, 0);
    check("rst_hs", 32'(bus.vga_hs), 32'd1);
    check("rst_vs", 32'(bus.vga_vs), 32'd1);
    check("rst_rgb", rgb_out(), 32'h000);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_frame_start", 32'(bus.frame_start), 32'd0);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    reset_n = 1'b1;

    // Waiting for the first (0,0): no reads, blank output.
    drive(5, 9, 0);
    drive(6, 9, 0);
    check("wait_rd_en", 32'(bus.mem_rd_en), 32'd0);
    drive(7, 9, 0);
    drive(8, 9, 0);
    drive(700, 9, 0);
    check("wait_rgb", rgb_out(), 32'h000);

    // Framebuffer frame: (5,9) -> addr 321, rgb 0x141 four cycles later.
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 9, 0);
    drive(5, 9, 0);
    drive(700, 9, 0);
    check("fb_addr", 32'(bus.mem_addr), 32'd321);
    check("fb_rd_en", 32'(bus.mem_rd_en), 32'd1);
    check("fb_fs_first", 32'(bus.frame_start), 32'd1);
    check("fb_fc_first", 32'(bus.frame_count), 32'd1);
    check("fb_rgb_0_0", rgb_out(), 32'h000);
    drive(700, 9, 0);
    check("fb_rd_en_blank", 32'(bus.mem_rd_en), 32'd0);
    check("fb_addr_hold", 32'(bus.mem_addr), 32'd321);
    check("fb_fs_width", 32'(bus.frame_start), 32'd0);
    drive(700, 9, 0);
    check("fb_rgb_0_9", rgb_out(), 32'h140);
    drive(700, 9, 0);
    check("fb_rgb_5_9", rgb_out(), 32'h141);
    exp_fc = 8'd1;

    // Sync alignment: output edge exactly L cycles after the input edge.
    repeat (5) drive(600, 10, 0);
    drive(656, 10, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(657, 10, 0);
      check($sformatf("hs_align_%0d", i), 32'(bus.vga_hs), (i < 4) ? 32'd1 : 32'd0);
    end
    repeat (5) drive(700, 480, 0);
    drive(700, 490, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(700, 491, 0);
      check($sformatf("vs_align_%0d", i), 32'(bus.vga_vs), (i < 4) ? 32'd1 : 32'd0);
    end

    // Bars, blanking, mid-frame switch to checker, then checker and grid frames.
    tbl.push_back('{0, 0, 1, 12'hFFF});
    tbl.push_back('{79, 0, 1, 12'hFFF});
    tbl.push_back('{80, 0, 1, 12'hFF0});
    tbl.push_back('{160, 5, 1, 12'h0FF});
    tbl.push_back('{240, 5, 1, 12'h0F0});
    tbl.push_back('{320, 5, 1, 12'hF0F});
    tbl.push_back('{400, 5, 1, 12'hF00});
    tbl.push_back('{480, 5, 1, 12'h00F});
    tbl.push_back('{560, 5, 1, 12'h000});
    tbl.push_back('{639, 479, 1, 12'h000});
    tbl.push_back('{640, 0, 1, 12'h000});
    tbl.push_back('{799, 479, 1, 12'h000});
    tbl.push_back('{0, 480, 1, 12'h000});
    tbl.push_back('{0, 524, 1, 12'h000});
    tbl.push_back('{32, 100, 2, 12'hFFF});
    tbl.push_back('{100, 100, 2, 12'hFF0});
    tbl.push_back('{0, 0, 2, 12'h000});
    tbl.push_back('{32, 0, 2, 12'hFFF});
    tbl.push_back('{64, 0, 2, 12'h000});
    tbl.push_back('{0, 32, 2, 12'hFFF});
    tbl.push_back('{32, 32, 2, 12'h000});
    tbl.push_back('{700, 32, 2, 12'h000});
    tbl.push_back('{0, 0, 3, 12'hFFF});
    tbl.push_back('{5, 5, 3, 12'h000});
    tbl.push_back('{5, 32, 3, 12'hFFF});
    tbl.push_back('{32, 7, 3, 12'hFFF});
    tbl.push_back('{33, 33, 3, 12'h000});
    tbl.push_back('{639, 479, 3, 12'h000});
    tbl.push_back('{640, 0, 3, 12'h000});
    run_tbl();

    // One-cycle reset mid-frame: blank and no reads until the next (0,0).
    repeat (3) drive(0, 200, 3);
    reset_n = 1'b0;
    drive(0, 201, 3);
    reset_n = 1'b1;
    exp_fc = 8'd0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 202 + i, 0);
      check($sformatf("postrst_rgb_%0d", i), rgb_out(), 32'h000);
      check($sformatf("postrst_rd_en_%0d", i), 32'(bus.mem_rd_en), 32'd0);
      check($sformatf("postrst_fc_%0d", i), 32'(bus.frame_count), 32'd0);
    end
    tbl.push_back('{0, 0, 1, 12'hFFF});
    tbl.push_back('{80, 0, 1, 12'hFF0});
    run_tbl();
    check("postrst_fc_one", 32'(bus.frame_count), 32'd1);

    // 256 more short frames: 257 since reset, count wraps to 1.
    for (int f = 0; f < 256; f++) begin
      tbl.push_back('{0, 0, 1, 12'hFFF});
      tbl.push_back('{1, 0, 1, 12'hFFF});
    end
    run_tbl();
    check("fc_wrap", 32'(bus.frame_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
